ssc_ramp_ctrl: RTL and testbench

SSC_RAMP_CTRL -- requirements
Module: ssc_ramp_ctrl

---
 rtl/ssc_ramp_ctrl.sv | 125 ++++++++++++
 tb/tb_ssc_ramp_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssc_ramp_ctrl.sv
// ssc_ramp_ctrl: spread-spectrum modulator sequencer (calibrate, ramp depth up, hold, ramp down).
// Ports: clk_in/rst_n clock and asynchronous active-low reset; en_req host run request;
//   tgt_profile/tgt_depth/tgt_freq targets, latched only when leaving IDLE; ramp_div cycles per
//   depth step minus one; calib_done_in from the modulator; ssc_* registered modulator controls;
//   busy/state_dbg/err_timeout status.
// Option: define SSC_RAMP_CTRL_CAL_TIMEOUT_EN to bound CALIB by CAL_TIMEOUT cycles (ERROR state).
module ssc_ramp_ctrl #(
  parameter int N_PHASE_BITS = 16,
  parameter int N_AMP_BITS = 8,
  parameter int CAL_TIMEOUT = 1024
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    en_req,
  input  logic [1:0]              tgt_profile,
  input  logic [N_AMP_BITS-1:0]   tgt_depth,
  input  logic [N_PHASE_BITS-1:0] tgt_freq,
  input  logic [7:0]              ramp_div,
  input  logic                    calib_done_in,
  output logic                    ssc_en,
  output logic [1:0]              ssc_profile,
  output logic [N_AMP_BITS-1:0]   ssc_mod_depth,
  output logic [N_PHASE_BITS-1:0] ssc_mod_freq,
  output logic                    ssc_calib_req,
  output logic                    busy,
  output logic [2:0]              state_dbg,
  output logic                    err_timeout
);
`ifdef SSC_RAMP_CTRL_CAL_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE = 3'd0, CALIB = 3'd1, RAMP_UP = 3'd2, ACTIVE = 3'd3, RAMP_DOWN = 3'd4, ERROR = 3'd5} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, CALIB = 3'd1, RAMP_UP = 3'd2, ACTIVE = 3'd3, RAMP_DOWN = 3'd4} state_t;
`endif
  state_t                  r_state, w_nxt;
  logic [1:0]              r_sh_profile;
  logic [N_AMP_BITS-1:0]   r_sh_depth, r_depth, w_depth;
  logic [N_PHASE_BITS-1:0] r_sh_freq;
  logic [7:0]              r_cnt;
  logic                    w_step, w_run;
  assign w_step = r_cnt == ramp_div;
  assign w_run = (w_nxt == RAMP_UP) || (w_nxt == ACTIVE) || (w_nxt == RAMP_DOWN);
  assign ssc_mod_depth = r_depth;
`ifdef SSC_RAMP_CTRL_CAL_TIMEOUT_EN
  logic [15:0] r_cal_cnt;
  logic        w_cal_to;
  // r_cal_cnt holds the number of CALIB cycles already spent before the current one
  assign w_cal_to = r_cal_cnt + 16'd1 == 16'(CAL_TIMEOUT);
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cal_cnt   <= '0;
      err_timeout <= 1'b0;
    end else begin
      r_cal_cnt   <= (r_state == CALIB && w_nxt == CALIB) ? r_cal_cnt + 16'd1 : '0;
      err_timeout <= w_nxt == ERROR;
    end
  end
`else
  // no timeout hardware: the flag is constant zero for any legal CAL_TIMEOUT
  assign err_timeout = 1'b0 & (CAL_TIMEOUT == 0);
`endif
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_nxt;
  end
  // en_req is tested first in every state so it overrides step and completion conditions
  always_comb begin
    w_nxt = r_state;
    w_depth = r_depth;
    case (r_state)
      IDLE: if (en_req) w_nxt = CALIB;
      CALIB: begin
        if (!en_req) w_nxt = IDLE;
        else if (calib_done_in) w_nxt = RAMP_UP;
`ifdef SSC_RAMP_CTRL_CAL_TIMEOUT_EN
        else if (w_cal_to) w_nxt = ERROR;
`endif
      end
      RAMP_UP: begin
        if (!en_req) w_nxt = RAMP_DOWN;
        else if (r_depth >= r_sh_depth) w_nxt = ACTIVE;
        else if (w_step) w_depth = r_depth + 1'b1;
      end
      ACTIVE: if (!en_req) w_nxt = RAMP_DOWN;
      RAMP_DOWN: begin
        if (en_req) w_nxt = RAMP_UP;
        else if (r_depth == '0) w_nxt = IDLE;
        else if (w_step) w_depth = r_depth - 1'b1;
      end
`ifdef SSC_RAMP_CTRL_CAL_TIMEOUT_EN
      ERROR: if (!en_req) w_nxt = IDLE;
`endif
      default: w_nxt = IDLE;
    endcase
  end
  // outputs are registered from the next state so they track r_state exactly
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_profile  <= '0;
      r_sh_depth    <= '0;
      r_sh_freq     <= '0;
      r_depth       <= '0;
      r_cnt         <= '0;
      ssc_en        <= 1'b0;
      ssc_profile   <= '0;
      ssc_mod_freq  <= '0;
      ssc_calib_req <= 1'b0;
      busy          <= 1'b0;
      state_dbg     <= '0;
    end else begin
      if (r_state == IDLE && en_req) begin
        r_sh_profile <= tgt_profile;
        r_sh_depth   <= tgt_depth;
        r_sh_freq    <= tgt_freq;
      end
      r_depth       <= w_depth;
      r_cnt         <= (w_nxt != r_state || w_step) ? '0 : r_cnt + 8'd1;
      ssc_en        <= w_run;
      ssc_profile   <= w_run ? r_sh_profile : '0;
      ssc_mod_freq  <= w_run ? r_sh_freq : '0;
      ssc_calib_req <= w_nxt == CALIB;
      busy          <= w_nxt != IDLE;
      state_dbg     <= w_nxt;
    end
  end
endmodule

// File: tb/tb_ssc_ramp_ctrl.sv
// tb_ssc_ramp_ctrl: randomized self-checking bench for ssc_ramp_ctrl against a depth-trajectory model.
// Honours SSC_RAMP_CTRL_CAL_TIMEOUT_EN for the calibration timeout scenario.
module tb_ssc_ramp_ctrl;
  localparam int NP = 16;
  localparam int NA = 8;
  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          en_req = 1'b0;
  logic          calib_done_in = 1'b0;
  logic [1:0]    tgt_profile = '0;
  logic [NA-1:0] tgt_depth = '0;
  logic [NP-1:0] tgt_freq = '0;
  logic [7:0]    ramp_div = '0;
  logic          ssc_en, ssc_calib_req, busy, err_timeout;
  logic [1:0]    ssc_profile;
  logic [NA-1:0] ssc_mod_depth;
  logic [NP-1:0] ssc_mod_freq;
  logic [2:0]    state_dbg;
  logic [32:0]   obs;
  int checks = 0;
  int errors = 0;
  int m_prof, m_freq, m_dep, m_cur, m_r;
  ssc_ramp_ctrl #(.N_PHASE_BITS(NP), .N_AMP_BITS(NA), .CAL_TIMEOUT(8)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en_req(en_req), .tgt_profile(tgt_profile),
    .tgt_depth(tgt_depth), .tgt_freq(tgt_freq), .ramp_div(ramp_div),
    .calib_done_in(calib_done_in), .ssc_en(ssc_en), .ssc_profile(ssc_profile),
    .ssc_mod_depth(ssc_mod_depth), .ssc_mod_freq(ssc_mod_freq),
    .ssc_calib_req(ssc_calib_req), .busy(busy), .state_dbg(state_dbg),
    .err_timeout(err_timeout)
  );
  always #5 clk_in = ~clk_in;
  assign obs = {state_dbg, ssc_en, ssc_calib_req, busy, err_timeout, ssc_profile, ssc_mod_freq, ssc_mod_depth};
  // Expected output vector for an abstract state and depth, using the latched host targets
  function automatic logic [32:0] exp_vec(input int st, input int dep);
    logic run;
    run = st >= 2 && st <= 4;
    return {3'(st), run, st == 1, st != 0, st == 5, run ? 2'(m_prof) : 2'b0, run ? 16'(m_freq) : 16'h0, 8'(dep)};
  endfunction
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic scramble;
    tgt_profile = 2'($urandom);
    tgt_depth = 8'($urandom);
    tgt_freq = 16'($urandom);
  endtask
  task automatic start_run(input int prof, input int dep, input int freq, input int delay);
    m_prof = prof;
    m_dep = dep;
    m_freq = freq;
    m_cur = 0;
    ramp_div = 8'(m_r);
    tgt_profile = 2'(prof);
    tgt_depth = 8'(dep);
    tgt_freq = 16'(freq);
    en_req = 1'b1;
    tick;
    for (int c = 1; c <= delay; c++) begin
      checks++;
      if (obs !== exp_vec(1, 0)) begin
        errors++;
        $display("FAIL calib c=%0d got=%h want=%h", c, obs, exp_vec(1, 0));
      end
      scramble;
      if (c == delay) calib_done_in = 1'b1;
      tick;
    end
    calib_done_in = 1'b0;
  endtask
  // Entered with RAMP_UP just visible; depth rises one step per (ramp_div+1) cycles
  task automatic ramp_up(input int kstop);
    int d0, kd;
    d0 = m_cur;
    kd = (m_dep - d0) * (m_r + 1);
    for (int k = 0; k <= kd; k++) begin
      m_cur = (d0 + k / (m_r + 1) > m_dep) ? m_dep : d0 + k / (m_r + 1);
      checks++;
      if (obs !== exp_vec(2, m_cur)) begin
        errors++;
        $display("FAIL ramp_up k=%0d got=%h want=%h", k, obs, exp_vec(2, m_cur));
      end
      if (k == kstop) return;
      scramble;
      tick;
      if (k == kd) begin
        checks++;
        if (obs !== exp_vec(3, m_dep)) begin
          errors++;
          $display("FAIL active_entry got=%h want=%h", obs, exp_vec(3, m_dep));
        end
      end
    end
  endtask
  // Entered with RAMP_DOWN just visible; depth falls one step per (ramp_div+1) cycles
  task automatic ramp_down(input int kstop);
    int d0, kd;
    d0 = m_cur;
    kd = d0 * (m_r + 1);
    for (int k = 0; k <= kd; k++) begin
      m_cur = (d0 - k / (m_r + 1) < 0) ? 0 : d0 - k / (m_r + 1);
      checks++;
      if (obs !== exp_vec(4, m_cur)) begin
        errors++;
        $display("FAIL ramp_down k=%0d got=%h want=%h", k, obs, exp_vec(4, m_cur));
      end
      if (k == kstop) return;
      scramble;
      tick;
      if (k == kd) begin
        checks++;
        if (obs !== exp_vec(0, 0)) begin
          errors++;
          $display("FAIL idle_entry got=%h want=%h", obs, exp_vec(0, 0));
        end
      end
    end
  endtask
  task automatic test_reset;
    en_req = 1'b1;
    scramble;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== exp_vec(0, 0)) begin
        errors++;
        $display("FAIL reset i=%0d got=%h want=%h", i, obs, exp_vec(0, 0));
      end
      tick;
    end
    en_req = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    tick;
    checks++;
    if (obs !== exp_vec(0, 0)) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs, exp_vec(0, 0));
    end
  endtask
  task automatic test_basic;
    m_r = 2;
    start_run(1, 4, 'h1234, 3);
    ramp_up(-1);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (obs !== exp_vec(3, 4)) begin
        errors++;
        $display("FAIL active_hold i=%0d got=%h want=%h", i, obs, exp_vec(3, 4));
      end
    end
    m_r = 0;
    ramp_div = 8'd0;
    en_req = 1'b0;
    tick;
    ramp_down(-1);
  endtask
  task automatic test_reverse;
    m_r = 1;
    start_run(2, 5, 'hBEEF, 2);
    ramp_up(-1);
    en_req = 1'b0;
    tick;
    ramp_down(6);
    en_req = 1'b1;
    tgt_depth = 8'd9;
    tick;
    ramp_up(-1);
    en_req = 1'b0;
    tick;
    ramp_down(-1);
  endtask
  task automatic test_zero_depth;
    m_r = $urandom_range(0, 3);
    start_run(3, 0, 'h00FF, 1);
    ramp_up(-1);
    en_req = 1'b0;
    tick;
    ramp_down(-1);
  endtask
  task automatic test_timeout;
    m_prof = 0;
    m_freq = 0;
    en_req = 1'b1;
    tick;
`ifdef SSC_RAMP_CTRL_CAL_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (obs !== exp_vec(1, 0)) begin
        errors++;
        $display("FAIL timeout_calib c=%0d got=%h want=%h", c, obs, exp_vec(1, 0));
      end
      tick;
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== exp_vec(5, 0)) begin
        errors++;
        $display("FAIL timeout_error i=%0d got=%h want=%h", i, obs, exp_vec(5, 0));
      end
      if (i == 0) tick;
    end
`else
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (obs !== exp_vec(1, 0)) begin
        errors++;
        $display("FAIL calib_wait c=%0d got=%h want=%h", c, obs, exp_vec(1, 0));
      end
      tick;
    end
`endif
    en_req = 1'b0;
    tick;
    checks++;
    if (obs !== exp_vec(0, 0)) begin
      errors++;
      $display("FAIL timeout_exit got=%h want=%h", obs, exp_vec(0, 0));
    end
  endtask
  task automatic test_reset_mid;
    m_r = 1;
    start_run(1, 6, 'h5A5A, 2);
    ramp_up(6);
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== exp_vec(0, 0)) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", obs, exp_vec(0, 0));
    end
    tick;
    checks++;
    if (obs !== exp_vec(0, 0)) begin
      errors++;
      $display("FAIL reset_mid_hold got=%h want=%h", obs, exp_vec(0, 0));
    end
    en_req = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_random;
    int mode, ks;
    for (int it = 0; it < 12; it++) begin
      m_r = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      start_run($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 65535), $urandom_range(1, 4));
      if (mode == 1) begin
        ks = $urandom_range(0, m_dep * (m_r + 1));
        ramp_up(ks);
      end else begin
        ramp_up(-1);
        for (int i = $urandom_range(0, 3); i > 0; i--) begin
          tick;
          checks++;
          if (obs !== exp_vec(3, m_dep)) begin
            errors++;
            $display("FAIL rand_hold it=%0d got=%h want=%h", it, obs, exp_vec(3, m_dep));
          end
        end
      end
      en_req = 1'b0;
      tick;
      if (mode == 2) begin
        ks = $urandom_range(0, m_cur * (m_r + 1));
        ramp_down(ks);
        en_req = 1'b1;
        tick;
        ramp_up(-1);
        en_req = 1'b0;
        tick;
      end
      ramp_down(-1);
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_reverse;
    test_zero_depth;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
